// File: rtl/sr_ccu_sched_pkg.sv
// sr_ccu_sched_pkg
//   Shared definitions for the CCU issue scheduler: FSM state encodings,
//   parameter defaults and the register-match helper used by the hazard
//   compare.
package sr_ccu_sched_pkg;

    localparam int CCU_DEPTH_DEF = 2;
    localparam int CCU_W_DEF     = 32;

    typedef enum logic [1:0] {
        CCU_S_IDLE = 2'd0,
        CCU_S_RUN  = 2'd1,
        CCU_S_WB   = 2'd2
    } ccu_state_e;

    // x0 is hardwired to zero, so it can never be the target of a hazard.
    function automatic logic rd_match(input logic [4:0] chk, input logic [4:0] rd);
        return (chk != 5'd0) && (chk == rd);
    endfunction

endpackage

// File: rtl/sr_ccu_sched_if.sv
// sr_ccu_sched_if
//   Bundles the scheduler's three buses: issue from decode (plus the hazard
//   probe), start/done handshake with the compute unit, and the deferred
//   register-file writeback.
//   slave  : scheduler view
//   master : environment view (decode, unit, register file)
interface sr_ccu_sched_if #(
    parameter int W = 32
);
    logic         iss_valid;
    logic         iss_ready;
    logic [W-1:0] iss_a;
    logic [W-1:0] iss_b;
    logic [4:0]   iss_rd;
    logic [4:0]   chk_rs1;
    logic [4:0]   chk_rs2;
    logic [4:0]   chk_rd;
    logic         hazard;
    logic         fu_start;
    logic [W-1:0] fu_a;
    logic [W-1:0] fu_b;
    logic         fu_done;
    logic [W-1:0] fu_y;
    logic         cpu_we;
    logic         wb_we;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         busy;

    modport slave (
        input  iss_valid, iss_a, iss_b, iss_rd,
        input  chk_rs1, chk_rs2, chk_rd,
        input  fu_done, fu_y, cpu_we,
        output iss_ready, hazard, fu_start, fu_a, fu_b,
        output wb_we, wb_rd, wb_data, busy
    );

    modport master (
        output iss_valid, iss_a, iss_b, iss_rd,
        output chk_rs1, chk_rs2, chk_rd,
        output fu_done, fu_y, cpu_we,
        input  iss_ready, hazard, fu_start, fu_a, fu_b,
        input  wb_we, wb_rd, wb_data, busy
    );

endinterface

// File: rtl/sr_ccu_fifo.sv
// sr_ccu_fifo
//   In-order issue queue of {a, b, rd}. DEPTH must be a power of two >= 2 so
//   the pointers wrap naturally.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     push_i, a_i, b_i, rd_i  enqueue (ignored when full)
//     pop_i                 dequeue head (ignored when empty)
//     count_o, full_o, empty_o  occupancy
//     head_a_o, head_b_o, head_rd_o  head entry
//     rd_all_o, vld_all_o   rd of every slot and whether it holds a live entry
module sr_ccu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               a_i,
    input  logic [W-1:0]               b_i,
    input  logic [4:0]                 rd_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [W-1:0]               head_a_o,
    output logic [W-1:0]               head_b_o,
    output logic [4:0]                 head_rd_o,
    output logic [4:0]                 rd_all_o [DEPTH],
    output logic [DEPTH-1:0]           vld_all_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  a_q  [DEPTH];
    logic [W-1:0]  b_q  [DEPTH];
    logic [4:0]    rd_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;

    assign head_a_o  = a_q[rd_ptr_q];
    assign head_b_o  = b_q[rd_ptr_q];
    assign head_rd_o = rd_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                rd_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                a_q[wr_ptr_q]  <= a_i;
                b_q[wr_ptr_q]  <= b_i;
                rd_q[wr_ptr_q] <= rd_i;
                wr_ptr_q       <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] off;
        assign off           = PW'(gi) - rd_ptr_q;
        assign vld_all_o[gi] = ({1'b0, off} < count_q);
        assign rd_all_o[gi]  = rd_q[gi];
    end

endmodule

// File: rtl/sr_ccu_sched.sv
// sr_ccu_sched
//   Issue scheduler for the multicycle compute unit. Queues ops from decode,
//   runs them one at a time through the unit's start/done handshake, holds
//   each result until the register-file port is free, and reports RAW
//   hazards against every in-flight destination register.
//   Ports:
//     clk, rst_n  core clock, async active-low reset
//     bus         sr_ccu_sched_if.slave (issue, hazard probe, unit, writeback)
//
//   state | meaning
//   IDLE  | waiting for a queued op; starts the head when the queue is non-empty
//   RUN   | op in the unit, waiting for fu_done
//   WB    | result held, waiting for a free register-file write port
module sr_ccu_sched
    import sr_ccu_sched_pkg::*;
#(
    parameter int DEPTH = CCU_DEPTH_DEF,
    parameter int W     = CCU_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_ccu_sched_if.slave      bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [W-1:0]    head_a;
    logic [W-1:0]    head_b;
    logic [4:0]      head_rd;
    logic [4:0]      rd_all [DEPTH];
    logic [DEPTH-1:0] vld_all;
    logic            pop;

    ccu_state_e      state_q;
    logic [4:0]      cur_rd_q;
    logic [W-1:0]    res_q;
    logic            in_wb;
    logic            hazard;

    sr_ccu_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (bus.iss_valid),
        .a_i       (bus.iss_a),
        .b_i       (bus.iss_b),
        .rd_i      (bus.iss_rd),
        .pop_i     (pop),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty),
        .head_a_o  (head_a),
        .head_b_o  (head_b),
        .head_rd_o (head_rd),
        .rd_all_o  (rd_all),
        .vld_all_o (vld_all)
    );

    // Start is decoded from registered state only, so nothing on the input
    // side can reach fu_start combinationally.
    assign pop          = (state_q == CCU_S_IDLE) && !empty;
    assign bus.fu_start = pop;
    assign bus.fu_a     = pop ? head_a : '0;
    assign bus.fu_b     = pop ? head_b : '0;

    assign bus.iss_ready = !full;
    assign bus.busy      = (count != '0) || (state_q != CCU_S_IDLE);

    // The core's own writeback always owns the port when it wants it.
    assign in_wb       = (state_q == CCU_S_WB);
    assign bus.wb_we   = in_wb && !bus.cpu_we && (cur_rd_q != 5'd0);
    assign bus.wb_rd   = in_wb ? cur_rd_q : 5'd0;
    assign bus.wb_data = in_wb ? res_q : '0;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_all[i]) begin
                hazard = hazard
                       | rd_match(bus.chk_rs1, rd_all[i])
                       | rd_match(bus.chk_rs2, rd_all[i])
                       | rd_match(bus.chk_rd,  rd_all[i]);
            end
        end
        if (state_q != CCU_S_IDLE) begin
            hazard = hazard
                   | rd_match(bus.chk_rs1, cur_rd_q)
                   | rd_match(bus.chk_rs2, cur_rd_q)
                   | rd_match(bus.chk_rd,  cur_rd_q);
        end
    end
    assign bus.hazard = hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CCU_S_IDLE;
            cur_rd_q <= 5'd0;
            res_q    <= '0;
        end else begin
            case (state_q)
                CCU_S_IDLE: begin
                    if (!empty) begin
                        cur_rd_q <= head_rd;
                        state_q  <= CCU_S_RUN;
                    end
                end
                CCU_S_RUN: begin
                    if (bus.fu_done) begin
                        res_q   <= bus.fu_y;
                        state_q <= CCU_S_WB;
                    end
                end
                CCU_S_WB: begin
                    // rd=0 results are discarded without waiting for the port.
                    if ((cur_rd_q == 5'd0) || !bus.cpu_we) begin
                        state_q <= CCU_S_IDLE;
                    end
                end
                default: state_q <= CCU_S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_ccu_sched.sv
module tb_sr_ccu_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_ccu_sched_if #(.W(32)) bus ();

    sr_ccu_sched #(.DEPTH(2), .W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    op_t opq[$];
    wb_t wbq[$];

    int          fu_lat = 4;
    int          fu_rem = 0;
    logic [31:0] fu_y_pend = '0;

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    // Compute-unit model: done pulse fu_lat cycles after the start cycle.
    always @(negedge clk) begin
        bus.fu_done = 1'b0;
        if (fu_rem > 0) begin
            fu_rem = fu_rem - 1;
            if (fu_rem == 0) begin
                bus.fu_done = 1'b1;
                bus.fu_y    = fu_y_pend;
            end
        end
        if (bus.fu_start === 1'b1) begin
            fu_rem    = fu_lat;
            fu_y_pend = unit_fn(bus.fu_a, bus.fu_b);
        end
    end

    // Scoreboard: issued ops must start in order, results must write back in order.
    always @(negedge clk) begin : mon
        op_t e;
        wb_t w;
        if (rst_n === 1'b1) begin
            if (bus.fu_start === 1'b1) begin
                checks++;
                if (opq.size() == 0) begin
                    errors++;
                    $display("FAIL fu_start_unexpected got a=%0d b=%0d expected no start", bus.fu_a, bus.fu_b);
                end else begin
                    e = opq.pop_front();
                    if (bus.fu_a !== e.a || bus.fu_b !== e.b) begin
                        errors++;
                        $display("FAIL fu_operands got a=%0d b=%0d expected a=%0d b=%0d", bus.fu_a, bus.fu_b, e.a, e.b);
                    end
                    if (e.rd != 5'd0) begin
                        w.rd   = e.rd;
                        w.data = unit_fn(e.a, e.b);
                        wbq.push_back(w);
                    end
                end
            end
            if (bus.wb_we === 1'b1) begin
                checks++;
                if (wbq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected got rd=%0d data=%0d expected no writeback", bus.wb_rd, bus.wb_data);
                end else begin
                    w = wbq.pop_front();
                    if (bus.wb_rd !== w.rd || bus.wb_data !== w.data) begin
                        errors++;
                        $display("FAIL wb_order got rd=%0d data=%0d expected rd=%0d data=%0d", bus.wb_rd, bus.wb_data, w.rd, w.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        op_t e;
        bus.iss_valid = 1'b1;
        bus.iss_a     = a;
        bus.iss_b     = b;
        bus.iss_rd    = rd;
        #1;
        while (bus.iss_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.iss_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got iss_ready=%b expected 1 within 50 cycles", bus.iss_ready);
            bus.iss_valid = 1'b0;
            return;
        end
        e.a  = a;
        e.b  = b;
        e.rd = rd;
        opq.push_back(e);
        tick();
        bus.iss_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0 || opq.size() != 0 || wbq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got busy=%b ops=%0d wbs=%0d expected 0/0/0", name, bus.busy, opq.size(), wbq.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_a     = '0;
        bus.iss_b     = '0;
        bus.iss_rd    = '0;
        bus.chk_rs1   = 5'd5;
        bus.chk_rs2   = 5'd0;
        bus.chk_rd    = 5'd0;
        bus.cpu_we    = 1'b0;
        bus.fu_y      = '0;
        #12;
        checks++;
        if (bus.iss_ready !== 1'b1 || bus.busy !== 1'b0 || bus.fu_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b start=%b expected 1/0/0", bus.iss_ready, bus.busy, bus.fu_start);
        end
        checks++;
        if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0 || bus.hazard !== 1'b0 || bus.fu_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got wb_we=%b wb_rd=%0d wb_data=%0d hazard=%b fu_a=%0d expected all 0",
                     bus.wb_we, bus.wb_rd, bus.wb_data, bus.hazard, bus.fu_a);
        end
        bus.chk_rs1 = 5'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        fu_lat = 4;
        issue(32'd7, 32'd3, 5'd5);
        checks++;
        if (bus.fu_start !== 1'b1 || bus.fu_a !== 32'd7 || bus.fu_b !== 32'd3) begin
            errors++;
            $display("FAIL single_start got start=%b a=%0d b=%0d expected 1/7/3", bus.fu_start, bus.fu_a, bus.fu_b);
        end
        tick();
        checks++;
        if (bus.fu_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_run got start=%b busy=%b expected 0/1", bus.fu_start, bus.busy);
        end
        repeat (4) tick();
        checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'd21) begin
            errors++;
            $display("FAIL single_wb got we=%b rd=%0d data=%0d expected 1/5/21", bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.wb_we !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_fall got busy=%b we=%b expected 0/0", bus.busy, bus.wb_we);
        end
        wait_idle("single");
    endtask

    task automatic test_contention();
        fu_lat = 2;
        issue(32'd100, 32'd3, 5'd7);
        bus.cpu_we = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wb_we !== 1'b0 || bus.busy !== 1'b1 || bus.wb_data !== 32'd300) begin
                errors++;
                $display("FAIL contention_hold cyc=%0d got we=%b busy=%b data=%0d expected 0/1/300", i, bus.wb_we, bus.busy, bus.wb_data);
            end
            tick();
        end
        bus.cpu_we = 1'b0;
        #1;
        checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'd300) begin
            errors++;
            $display("FAIL contention_release got we=%b rd=%0d data=%0d expected 1/7/300", bus.wb_we, bus.wb_rd, bus.wb_data);
        end
        tick();
        checks++;
        if (bus.wb_we !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_once got we=%b busy=%b expected 0/0", bus.wb_we, bus.busy);
        end
        wait_idle("contention");
    endtask

    task automatic test_fill();
        int n = 0;
        fu_lat = 6;
        issue(32'd2, 32'd3, 5'd10);
        issue(32'd4, 32'd5, 5'd11);
        issue(32'd6, 32'd7, 5'd12);
        checks++;
        if (bus.iss_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_full got ready=%b busy=%b expected 0/1", bus.iss_ready, bus.busy);
        end
        while (bus.iss_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.iss_ready !== 1'b1 || n != 7 || bus.fu_start !== 1'b0) begin
            errors++;
            $display("FAIL fill_recover got ready=%b after=%0d start=%b expected 1/7/0", bus.iss_ready, n, bus.fu_start);
        end
        wait_idle("fill");
    endtask

    task automatic test_hazard();
        fu_lat = 8;
        issue(32'd1, 32'd1, 5'd9);
        bus.chk_rs2 = 5'd9;
        #1;
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_queued got %b expected 1", bus.hazard);
        end
        bus.chk_rs2 = 5'd0;
        issue(32'd2, 32'd2, 5'd0);
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_x0 got %b expected 0", bus.hazard);
        end
        bus.chk_rs1 = 5'd8;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_nomatch got %b expected 0", bus.hazard);
        end
        bus.chk_rs1 = 5'd0;
        bus.chk_rs2 = 5'd9;
        #1;
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_running_rs2 got %b expected 1", bus.hazard);
        end
        bus.chk_rs2 = 5'd0;
        bus.chk_rd  = 5'd9;
        #1;
        checks++;
        if (bus.hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_running_rd got %b expected 1", bus.hazard);
        end
        bus.chk_rd = 5'd0;
        wait_idle("hazard");
        bus.chk_rs2 = 5'd9;
        #1;
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_after_wb got %b expected 0", bus.hazard);
        end
        bus.chk_rs2 = 5'd0;
    endtask

    task automatic test_rd0();
        fu_lat = 3;
        issue(32'd5, 32'd5, 5'd0);
        checks++;
        if (bus.fu_start !== 1'b1 || bus.fu_a !== 32'd5) begin
            errors++;
            $display("FAIL rd0_start got start=%b a=%0d expected 1/5", bus.fu_start, bus.fu_a);
        end
        repeat (4) tick();
        checks++;
        if (bus.wb_we !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rd0_wb got we=%b busy=%b expected 0/1", bus.wb_we, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rd0_idle got busy=%b expected 0", bus.busy);
        end
        wait_idle("rd0");
    endtask

    task automatic test_reset_mid_run();
        fu_lat = 10;
        issue(32'd3, 32'd3, 5'd4);
        issue(32'd6, 32'd6, 5'd6);
        tick();
        tick();
        bus.chk_rd  = 5'd4;
        bus.chk_rs1 = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.iss_ready !== 1'b1 || bus.busy !== 1'b0 || bus.fu_start !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_ctrl got ready=%b busy=%b start=%b expected 1/0/0", bus.iss_ready, bus.busy, bus.fu_start);
        end
        checks++;
        if (bus.hazard !== 1'b0 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset_data got hazard=%b we=%b data=%0d expected 0/0/0", bus.hazard, bus.wb_we, bus.wb_data);
        end
        opq.delete();
        wbq.delete();
        bus.chk_rd  = 5'd0;
        bus.chk_rs1 = 5'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (bus.wb_we !== 1'b0 || bus.fu_start !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_stray cyc=%0d got we=%b start=%b busy=%b expected 0/0/0", i, bus.wb_we, bus.fu_start, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fill();
        test_hazard();
        test_rd0();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
